// File: rtl/control_register_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : control_register_decoder
//  Purpose  : Parses framed control messages (SYNC, CMD, payload LSB-first,
//             CHK) from the SPI byte stream and maintains the channel mask,
//             trigger level and sample clock divider registers.
//             CHK is the XOR of CMD and all payload bytes.
//  Ports    : clk            - system clock, rising edge
//             rst            - asynchronous active-high reset
//             spi_byte       - received SPI byte
//             spi_byte_valid - spi_byte is consumed this cycle when high
//             channel_mask   - enabled channels (NUM_CHANNELS bits)
//             trigger_level  - trigger threshold
//             clock_divider  - sample clock divider
//             config_update  - one-cycle pulse, a register was committed
//             error          - one-cycle pulse, a frame was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module control_register_decoder #(
    parameter int         NUM_CHANNELS   = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hFE,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              spi_byte,
    input  logic                    spi_byte_valid,
    output logic [NUM_CHANNELS-1:0] channel_mask,
    output logic [7:0]              trigger_level,
    output logic [15:0]             clock_divider,
    output logic                    config_update,
    output logic                    error
);

    localparam int c_mask_bytes   = (NUM_CHANNELS + 7) / 8;
    // Shadow must hold the longest payload: the mask or the 2-byte divider.
    localparam int c_shadow_bytes = (c_mask_bytes > 2) ? c_mask_bytes : 2;
    localparam int c_idx_w        = $clog2(c_shadow_bytes) + 1;
    localparam int c_tmr_w        = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] c_cmd_mask    = 8'h01;
    localparam logic [7:0] c_cmd_trigger = 8'h02;
    localparam logic [7:0] c_cmd_divider = 8'h03;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_cmd     = 2'd1;
    localparam logic [1:0] c_st_payload = 2'd2;
    localparam logic [1:0] c_st_check   = 2'd3;

    logic [1:0]                  r_state;
    logic [7:0]                  r_cmd;
    logic [c_idx_w-1:0]          r_len;
    logic [c_idx_w-1:0]          r_idx;
    logic [7:0]                  r_chk;
    logic [c_shadow_bytes*8-1:0] r_shadow;
    logic [c_tmr_w-1:0]          r_timer;
    logic [NUM_CHANNELS-1:0]     r_channel_mask;
    logic [7:0]                  r_trigger_level;
    logic [15:0]                 r_clock_divider;
    logic                        r_config_update;
    logic                        r_error;

    logic                        w_cmd_known;
    logic [c_idx_w-1:0]          w_cmd_len;

    // Payload length lookup for the byte currently on the bus (used in CMD).
    always_comb begin
        w_cmd_known = 1'b0;
        w_cmd_len   = '0;
        case (spi_byte)
            c_cmd_mask: begin
                w_cmd_known = 1'b1;
                w_cmd_len   = c_idx_w'(c_mask_bytes);
            end
            c_cmd_trigger: begin
                w_cmd_known = 1'b1;
                w_cmd_len   = c_idx_w'(1);
            end
            c_cmd_divider: begin
                w_cmd_known = 1'b1;
                w_cmd_len   = c_idx_w'(2);
            end
            default: begin
                w_cmd_known = 1'b0;
                w_cmd_len   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_st_idle;
            r_cmd           <= '0;
            r_len           <= '0;
            r_idx           <= '0;
            r_chk           <= '0;
            r_shadow        <= '0;
            r_timer         <= '0;
            r_channel_mask  <= '0;
            r_trigger_level <= 8'h80;
            r_clock_divider <= '0;
            r_config_update <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_config_update <= 1'b0;
            r_error         <= 1'b0;

            // Inter-byte timeout: only armed while a frame is in progress.
            if (r_state == c_st_idle || spi_byte_valid) begin
                r_timer <= '0;
            end else if (r_timer == c_tmr_last) begin
                r_timer <= '0;
                r_error <= 1'b1;
                r_state <= c_st_idle;
            end else begin
                r_timer <= r_timer + c_tmr_w'(1);
            end

            if (spi_byte_valid) begin
                case (r_state)
                    c_st_idle: begin
                        if (spi_byte == SYNC_BYTE) begin
                            r_state <= c_st_cmd;
                        end
                    end
                    c_st_cmd: begin
                        if (w_cmd_known) begin
                            r_cmd    <= spi_byte;
                            r_len    <= w_cmd_len;
                            r_idx    <= '0;
                            r_chk    <= spi_byte;
                            r_shadow <= '0;
                            r_state  <= c_st_payload;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= c_st_idle;
                        end
                    end
                    c_st_payload: begin
                        for (int b = 0; b < c_shadow_bytes; b++) begin
                            if (r_idx == c_idx_w'(b)) begin
                                r_shadow[b*8 +: 8] <= spi_byte;
                            end
                        end
                        r_chk <= r_chk ^ spi_byte;
                        r_idx <= r_idx + c_idx_w'(1);
                        if (r_idx == r_len - c_idx_w'(1)) begin
                            r_state <= c_st_check;
                        end
                    end
                    default: begin
                        // CHECK: commit the whole shadow at once or drop it.
                        if (spi_byte == r_chk) begin
                            case (r_cmd)
                                c_cmd_mask:    r_channel_mask  <= r_shadow[NUM_CHANNELS-1:0];
                                c_cmd_trigger: r_trigger_level <= r_shadow[7:0];
                                default:       r_clock_divider <= r_shadow[15:0];
                            endcase
                            r_config_update <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign channel_mask  = r_channel_mask;
    assign trigger_level = r_trigger_level;
    assign clock_divider = r_clock_divider;
    assign config_update = r_config_update;
    assign error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_control_register_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_register_decoder
//  Purpose  : Self-checking bench for control_register_decoder with
//             NUM_CHANNELS=12 and TIMEOUT_CYCLES=16. A frame-level model
//             predicts every output each cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_register_decoder;

    localparam int         NC = 12;
    localparam int         TO = 16;
    localparam logic [7:0] SY = 8'hFE;

    logic          clk;
    logic          rst;
    logic [7:0]    spi_byte;
    logic          spi_byte_valid;
    logic [NC-1:0] channel_mask;
    logic [7:0]    trigger_level;
    logic [15:0]   clock_divider;
    logic          config_update;
    logic          error;

    control_register_decoder #(
        .NUM_CHANNELS  (NC),
        .SYNC_BYTE     (SY),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spi_byte      (spi_byte),
        .spi_byte_valid(spi_byte_valid),
        .channel_mask  (channel_mask),
        .trigger_level (trigger_level),
        .clock_divider (clock_divider),
        .config_update (config_update),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [NC-1:0] m_mask;
    logic [7:0]    m_trig;
    logic [15:0]   m_div;
    logic          m_upd;
    logic          m_err;
    int            m_idle;
    logic [7:0]    frame[$];

    function automatic int paylen(input logic [7:0] cmd);
        case (cmd)
            8'h01:   return (NC + 7) / 8;
            8'h02:   return 1;
            8'h03:   return 2;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mask = '0; m_trig = 8'h80; m_div = '0;
            m_upd = 1'b0; m_err = 1'b0; m_idle = 0;
            frame.delete();
        end else begin
            m_upd = 1'b0;
            m_err = 1'b0;
            if (spi_byte_valid) begin
                m_idle = 0;
                if (frame.size() == 0) begin
                    if (spi_byte == SY) frame.push_back(spi_byte);
                end else begin
                    int need;
                    frame.push_back(spi_byte);
                    need = paylen(frame[1]);
                    if (need < 0) begin
                        m_err = 1'b1;
                        frame.delete();
                    end else if (frame.size() == need + 3) begin
                        logic [7:0]  x;
                        logic [31:0] v;
                        x = 8'h00;
                        v = 32'h0;
                        for (int i = 1; i < need + 2; i++) x ^= frame[i];
                        for (int i = 0; i < need; i++) v |= 32'(frame[2+i]) << (8 * i);
                        if (x == frame[need+2]) begin
                            m_upd = 1'b1;
                            case (frame[1])
                                8'h01:   m_mask = v[NC-1:0];
                                8'h02:   m_trig = v[7:0];
                                default: m_div  = v[15:0];
                            endcase
                        end else begin
                            m_err = 1'b1;
                        end
                        frame.delete();
                    end
                end
            end else if (frame.size() != 0) begin
                if (m_idle == TO - 1) begin
                    m_err = 1'b1;
                    m_idle = 0;
                    frame.delete();
                end else begin
                    m_idle++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_mask", 32'(channel_mask), 32'(m_mask));
            chk("model_trig", 32'(trigger_level), 32'(m_trig));
            chk("model_div", 32'(clock_divider), 32'(m_div));
            chk("model_upd", 32'(config_update), 32'(m_upd));
            chk("model_err", 32'(error), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        spi_byte       = b;
        spi_byte_valid = 1'b1;
        @(negedge clk);
        spi_byte_valid = 1'b0;
        spi_byte       = 8'h00;
    endtask

    task automatic send_seq(input logic [7:0] bs[$]);
        foreach (bs[i]) send(bs[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mask"}, 32'(channel_mask), 32'h0);
        chk({tag, "_trig"}, 32'(trigger_level), 32'h80);
        chk({tag, "_div"}, 32'(clock_divider), 32'h0);
        chk({tag, "_upd"}, 32'(config_update), 32'h0);
        chk({tag, "_err"}, 32'(error), 32'h0);
    endtask

    initial begin
        rst            = 1'b1;
        spi_byte       = 8'h00;
        spi_byte_valid = 1'b0;
        idle(2);
        chk_reset_vals("reset");
        rst = 1'b0;
        idle(1);

        // Channel mask frame, 12 channels -> 2 payload bytes.
        send_seq('{SY, 8'h01, 8'hD2, 8'h0A});
        send(8'hD9);
        chk("s1_mask", 32'(channel_mask), 32'hAD2);
        chk("s1_upd", 32'(config_update), 32'h1);
        chk("s1_err", 32'(error), 32'h0);
        idle(1);
        chk("s1_upd_end", 32'(config_update), 32'h0);

        // Back-to-back trigger and divider frames.
        send_seq('{SY, 8'h02, 8'h40});
        send(8'h42);
        chk("s2_trig", 32'(trigger_level), 32'h40);
        chk("s2_upd1", 32'(config_update), 32'h1);
        send_seq('{SY, 8'h03, 8'h34, 8'h12});
        send(8'h25);
        chk("s2_div", 32'(clock_divider), 32'h1234);
        chk("s2_upd2", 32'(config_update), 32'h1);
        chk("s2_mask", 32'(channel_mask), 32'hAD2);

        // Bad checksum, then a good frame.
        send_seq('{SY, 8'h02, 8'h40});
        send(8'h43);
        chk("s3_err", 32'(error), 32'h1);
        chk("s3_upd", 32'(config_update), 32'h0);
        chk("s3_trig", 32'(trigger_level), 32'h40);
        idle(1);
        chk("s3_err_end", 32'(error), 32'h0);
        send_seq('{SY, 8'h02, 8'h55});
        send(8'h57);
        chk("s3_trig2", 32'(trigger_level), 32'h55);

        // Unknown command; remainder is discarded in IDLE.
        send(SY);
        send(8'h07);
        chk("s4_err", 32'(error), 32'h1);
        send_seq('{8'h01, 8'hD2, 8'h0A});
        send(8'hD9);
        chk("s4_upd", 32'(config_update), 32'h0);
        chk("s4_mask", 32'(channel_mask), 32'hAD2);

        // Timeout after 16 idle cycles.
        send_seq('{SY, 8'h01, 8'hD2});
        idle(TO - 1);
        chk("to_no_err", 32'(error), 32'h0);
        idle(1);
        chk("to_err", 32'(error), 32'h1);
        send_seq('{8'h0A, 8'hD9});
        chk("to_discard", 32'(config_update), 32'h0);

        // Byte arriving on the 16th cycle keeps the frame alive.
        send_seq('{SY, 8'h01, 8'h34});
        idle(TO - 1);
        send(8'h05);
        chk("to_edge_err", 32'(error), 32'h0);
        send(8'h30);
        chk("to_edge_upd", 32'(config_update), 32'h1);
        chk("to_edge_mask", 32'(channel_mask), 32'h534);

        // Asynchronous reset between payload bytes.
        send_seq('{SY, 8'h03, 8'h78});
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        idle(2);
        rst = 1'b0;
        send(8'h56);
        chk("post_rst_err", 32'(error), 32'h0);
        send_seq('{SY, 8'h03, 8'h78, 8'h56});
        send(8'h2D);
        chk("post_rst_div", 32'(clock_divider), 32'h5678);
        chk("post_rst_upd", 32'(config_update), 32'h1);
        chk("post_rst_mask", 32'(channel_mask), 32'h0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_register_decoder.md
Name: control_register_decoder

Overview:
- Parametrised successor to the single-command channel-mask decoder.
- Parses framed control messages from the SPI byte stream and maintains three configuration registers: channel mask, trigger level and sample clock divider.
- Adds a byte-valid qualifier, multi-byte payloads, an XOR checksum, error reporting and an inter-byte timeout.
- Sits between the SPI slave byte assembler and the capture/trigger logic.

Parameters:
NUM_CHANNELS, 8, width of channel_mask; legal range 1..32; MASK_BYTES = ceil(NUM_CHANNELS/8)
SYNC_BYTE, 8'hFE, frame start marker
TIMEOUT_CYCLES, 1024, max clk cycles between valid bytes inside a frame; legal range >= 2

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
spi_byte  input  8  received SPI byte
spi_byte_valid  input  1  spi_byte is valid this cycle; one byte consumed per cycle when high
channel_mask  output  NUM_CHANNELS  enabled channels
trigger_level  output  8  trigger threshold
clock_divider  output  16  sample clock divider
config_update  output  1  one-cycle pulse: a register was committed
error  output  1  one-cycle pulse: frame dropped (bad cmd, bad checksum, timeout)

Behaviour:
- Reset is asynchronous and active-high on rst. Reset values: channel_mask=0, trigger_level=8'h80, clock_divider=0, config_update=0, error=0, state=IDLE, counters=0.
- Frame format: SYNC, CMD, payload (LSB byte first), CHK. CHK = XOR of CMD and all payload bytes.
- Commands and payload lengths:
  - 8'h01: channel mask, MASK_BYTES bytes.
  - 8'h02: trigger level, 1 byte.
  - 8'h03: clock divider, 2 bytes.
- Only cycles with spi_byte_valid=1 advance the FSM. Bytes with valid=0 are ignored.
- FSM states and transitions:
  - IDLE: byte == SYNC_BYTE -> CMD. Any other byte is discarded silently, with no error pulse.
  - CMD: known cmd -> PAYLOAD. Latch cmd, set the expected length, clear the byte index, init checksum = cmd. Unknown cmd -> pulse error, go to IDLE.
  - PAYLOAD: store the byte into a shadow register at the byte index and XOR it into the checksum. Advance to CHECK after the last payload byte. SYNC_BYTE value is plain data here.
  - CHECK:
    - byte == checksum: commit the shadow to the target register, pulse config_update, go to IDLE.
    - mismatch: no commit, pulse error, go to IDLE.
- Latency: the new register value and config_update become visible after the rising edge that samples the CHK byte. The pulse is high for exactly that one following cycle. Registers are never partially updated.
- Width rules: shadow payload bits above NUM_CHANNELS are discarded on commit. Clock divider is assembled as {byte1, byte0}.
- Timeout:
  - In any state other than IDLE, a counter increments each cycle that valid=0 and clears on valid=1.
  - When the counter reaches TIMEOUT_CYCLES-1 with valid=0, pulse error and go to IDLE.
  - If valid=1 in that same cycle, the byte is processed normally and the counter clears; there is no error.
  - The counter is held at 0 in IDLE.
- A frame's final byte that commits or errors returns the FSM to IDLE. A SYNC_BYTE arriving in the next valid cycle starts a new frame, so back-to-back frames need no gaps.
- Reset mid-frame: the frame is abandoned and registers return to their reset values. There is no commit and no error pulse.
- config_update and error are never high in the same cycle.

Test Plan:
- NUM_CHANNELS=12, send FE 01 D2 0A D9 with valid every cycle -> channel_mask=12'hAD2 and config_update=1 for one cycle after the D9 edge; error stays 0.
- Send FE 02 40 42, then FE 03 34 12 25 back-to-back -> trigger_level=8'h40, then clock_divider=16'h1234. Two config_update pulses; channel_mask unchanged.
- Send FE 02 40 43 (bad CHK) -> error pulse one cycle; trigger_level keeps its previous value; no config_update. Next valid FE 02 55 57 then commits 8'h55.
- Send FE 07 -> error pulse after the 07 byte. The following 01 D2 0A D9 is discarded in IDLE, and channel_mask is unchanged.
- TIMEOUT_CYCLES=16: send FE 01 D2, then hold valid=0 -> error after 16 idle cycles, state IDLE. Repeat with a valid byte arriving exactly on cycle 16 -> no error, frame continues.
- Assert rst asynchronously between payload bytes -> all outputs at reset values immediately. A full subsequent frame decodes correctly; no spurious error pulse.
